spi_adc_reader: RTL and testbench
=================================

# spi_adc_reader

SPI master that periodically reads one 12-bit conversion from an external SPI ADC (MCP3201-style framing, mode 0) and presents it as a `data` word with a one-cycle `new_data` strobe. It is the sample producer for downstream consumers such as the LED bargraph, which latch `data` when `new_data` is high. It owns the ADC chip-select, serial clock and MISO input, plus the conversion-rate timer.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period; must be ≥ 2.
- `SAMPLE_PERIOD`, 50000: `clk` cycles between conversion starts; must be ≥ 2·CLK_DIV·(FRAME_BITS+2).
- `FRAME_BITS`, 16: SCLK rising edges per frame.
- `LEAD_BITS`, 3: leading rising edges discarded (sample window plus null bit).

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: conversions are started only while high.
- `spi_miso` in 1: ADC serial data, MSB first.
- `spi_cs_n` out 1: ADC chip select, active low. Reset value 1.
- `spi_sclk` out 1: serial clock, idle low. Reset value 0.
- `data` out 12: last completed conversion, held between frames. Reset value 0.
- `new_data` out 1: one-`clk` pulse when `data` updates. Reset value 0.
- `busy` out 1: high from CS assertion through the end of HOLD. Reset value 0.

## Operation
- Sample timer:
  - Free-running down-counter from SAMPLE_PERIOD−1 to 0, then wraps.
  - At 0 it raises a start request if `en`=1 and the FSM is in IDLE; otherwise the request is dropped, not queued.
- States, IDLE → SETUP → SHIFT → HOLD → IDLE:
  - IDLE: `spi_cs_n`=1, `spi_sclk`=0. Goes to SETUP on a start request.
  - SETUP: `spi_cs_n`=0, `spi_sclk`=0 for CLK_DIV cycles, then SHIFT.
  - SHIFT: SCLK toggles every CLK_DIV cycles, starting with a rising edge.
    - On the `clk` edge that drives SCLK 0→1, `spi_miso` is captured and the bit counter increments.
    - Rising edges 1..LEAD_BITS are discarded.
    - Edges LEAD_BITS+1 .. LEAD_BITS+12 shift into a 12-bit register, MSB first.
    - Any remaining edges up to FRAME_BITS are ignored.
    - After the FRAME_BITS-th falling edge (SCLK back at 0), go to HOLD.
  - HOLD: `spi_cs_n`=1 for CLK_DIV cycles.
    - On the first HOLD cycle, `data` loads the shift register and `new_data` pulses.
    - Then go to IDLE.
- `en` falling mid-frame does not abort the frame; it only blocks future starts.
- Bit counter width is clog2(FRAME_BITS+1); no wrap inside a frame.
- Async reset at any point:
  - Outputs go to their reset values immediately.
  - The timer reloads to SAMPLE_PERIOD−1.
  - The shift register and counters clear.
  - A partial frame never produces `new_data`.

## Timing
- Start request to `spi_cs_n` falling: 1 cycle.
- `spi_cs_n` falling to first SCLK rise: CLK_DIV cycles.
- SCLK period: 2·CLK_DIV cycles; duty cycle 50%.
- Frame length, CS low to CS high: CLK_DIV·(2·FRAME_BITS+1) cycles.
- `new_data` is asserted in the same cycle `spi_cs_n` rises; `data` is valid from that cycle.
- Consecutive `new_data` pulses are exactly SAMPLE_PERIOD cycles apart while `en`=1.
- First start after reset release: SAMPLE_PERIOD cycles later.

## Structure
- Package `adc_spi_pkg` holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD);
  - `DATA_BITS`=12;
  - defaults for FRAME_BITS and LEAD_BITS.
- Sub-module `spi_clk_div`:
  - Runs the CLK_DIV half-period counter.
  - Emits `rise_tick` and `fall_tick`.
  - Its counter is enabled only in SETUP and SHIFT.
- The FSM, sample timer and shift register live in the top level.

## Test plan
- Reset checks:
  - Reset: `spi_cs_n`=1, `spi_sclk`=0, `data`=0, `new_data`=0, `busy`=0.
  - Reset released with `en`=1: the first `spi_cs_n` fall happens after SAMPLE_PERIOD+1 cycles.
- Conversion with CLK_DIV=4, SAMPLE_PERIOD=200:
  - ADC model drives value 0xA5C on falling edges after the null bit.
  - Expected: exactly 16 SCLK rises, then `data`=0xA5C and a one-cycle `new_data` in the cycle CS rises.
  - CS is low for 132 cycles.
- Boundary values: ADC returns 0x000, then 0xFFF, on consecutive frames. Expected: `data` matches each value, with `new_data` pulses 200 cycles apart.
- `en` behaviour:
  - `en` dropped at SCLK rise 5: the frame completes with a valid `new_data`, and no further frames start.
  - `en` raised again: the next frame starts on the following timer wrap.
- Reset mid-frame: `rst_n` asserted at SCLK rise 8.
  - Expected: CS goes high and SCLK low asynchronously, and `data` keeps its reset value 0.
  - No `new_data` pulse occurs.
  - After release, the next full frame reads correctly.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the SPI ADC reader.
package adc_spi_pkg;

    localparam int DATA_BITS      = 12;
    localparam int FRAME_BITS_DEF = 16;
    localparam int LEAD_BITS_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period generator: alternating rise/fall ticks every CLK_DIV cycles.
// Counter and phase clear whenever disabled, so each frame starts with a rise tick.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          tick;

    // Half-period count and rise/fall phase selection
    always_comb begin
        tick    = en && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d   = '0;
        phase_d = 1'b0;
        if (en) begin
            cnt_d   = tick ? '0 : cnt_q + CW'(1);
            phase_d = tick ? ~phase_q : phase_q;
        end
        rise_tick = tick && !phase_q;
        fall_tick = tick && phase_q;
    end

    // Divider state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/spi_adc_reader.sv
// Periodic SPI (mode 0) reader for an MCP3201-style 12-bit ADC.
module spi_adc_reader
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int FRAME_BITS    = FRAME_BITS_DEF,
    parameter int LEAD_BITS     = LEAD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 spi_miso,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic [DATA_BITS-1:0] data,
    output logic                 new_data,
    output logic                 busy
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int HW = $clog2(CLK_DIV);

    state_e               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 start_q, start_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 sclk_q, sclk_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 nd_q, nd_d;
    logic                 div_en, rise_tick, fall_tick, in_window;

    assign div_en   = (state_q == SETUP) || (state_q == SHIFT);
    assign spi_cs_n = !div_en;
    assign spi_sclk = sclk_q;
    assign data     = data_q;
    assign new_data = nd_q;
    assign busy     = (state_q != IDLE);

    // Bits after the lead-in are the 12 data bits, MSB first
    assign in_window = (bit_q >= BW'(LEAD_BITS)) && (bit_q < BW'(LEAD_BITS + DATA_BITS));

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (div_en),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    // Conversion-rate timer; a wrap while busy or disabled is simply dropped
    always_comb begin
        tmr_d   = (tmr_q == '0) ? TW'(SAMPLE_PERIOD - 1) : tmr_q - TW'(1);
        start_d = (tmr_q == '0) && en && (state_q == IDLE);
    end

    // Frame FSM: SETUP's tick doubles as the first SCLK rise; the tick after the
    // last fall closes the frame and publishes the result
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        sclk_d  = sclk_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        nd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                if (start_q) begin
                    state_d = SETUP;
                    bit_d   = '0;
                    shreg_d = '0;
                end
            end
            SETUP, SHIFT: begin
                if (rise_tick) begin
                    if (bit_q == BW'(FRAME_BITS)) begin
                        state_d = HOLD;
                        hold_d  = '0;
                        data_d  = shreg_q;
                        nd_d    = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        sclk_d  = 1'b1;
                        bit_d   = bit_q + BW'(1);
                        if (in_window) shreg_d = {shreg_q[DATA_BITS-2:0], spi_miso};
                    end
                end else if (fall_tick) begin
                    sclk_d = 1'b0;
                end
            end
            HOLD: begin
                if (hold_q == HW'(CLK_DIV - 1)) state_d = IDLE;
                else                            hold_d  = hold_q + HW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= TW'(SAMPLE_PERIOD - 1);
            start_q <= 1'b0;
            bit_q   <= '0;
            hold_q  <= '0;
            sclk_q  <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            nd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            start_q <= start_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            sclk_q  <= sclk_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            nd_q    <= nd_d;
        end
    end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Bench for spi_adc_reader: ADC model on the SPI pins, scoreboard of expected
// conversions filled at each CS fall and drained on each new_data pulse.
module tb_spi_adc_reader;

    localparam int CLK_DIV = 4;
    localparam int P       = 200;
    localparam int FB      = 16;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, spi_miso = 1'b0;
    logic        spi_cs_n, spi_sclk, new_data, busy;
    logic [11:0] data;

    int n_tests = 0, n_fail = 0;

    spi_adc_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(P), .FRAME_BITS(FB), .LEAD_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .data(data),
        .new_data(new_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // clk edges since reset release
    int ecnt;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    // ADC model: picks a value per frame, drives its bits after falling SCLK edges
    logic [11:0] adc_q[$];
    logic [11:0] sb[$];
    logic [11:0] adc_val = '0;
    int          fcnt = 0;

    always @(negedge spi_cs_n) begin
        adc_val  = (adc_q.size() > 0) ? adc_q.pop_front() : 12'($urandom);
        sb.push_back(adc_val);
        fcnt     = 0;
        spi_miso = 1'b0;
    end

    always @(negedge spi_sclk) begin
        fcnt++;
        spi_miso = (fcnt >= 3 && fcnt <= 14) ? adc_val[14-fcnt] : 1'b0;
    end

    // Monitor: frame shape, pulse width, scoreboard drain
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_nd = 1'b0;
    int   cs_len = 0, rises = 0, n_fall = 0, n_nd = 0, fall_e = 0, nd_e = 0, nd_e_prev = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_nd = 1'b0;
            rises = 0; cs_len = 0;
        end else begin
            if (prev_cs && !spi_cs_n) begin
                n_fall++; fall_e = ecnt; rises = 0; cs_len = 0;
            end
            if (!spi_cs_n) begin
                cs_len++;
                if (!prev_sclk && spi_sclk) rises++;
            end
            if (!prev_cs && spi_cs_n) begin
                chk("cs_low_len", cs_len, 132);
                chk("sclk_rises", rises, FB);
                chk("nd_at_cs_rise", {31'b0, new_data}, 1);
            end
            if (new_data) begin
                n_nd++; nd_e_prev = nd_e; nd_e = ecnt;
                chk("nd_width", {31'b0, prev_nd}, 0);
                chk("nd_expected", {31'b0, sb.size() > 0}, 1);
                if (sb.size() > 0) chk("data", {20'b0, data}, {20'b0, sb.pop_front()});
            end
            prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_nd = new_data;
        end
    end

    task automatic wait_fall(input string tag, input int maxc);
        int s = n_fall;
        int i = 0;
        while (n_fall == s && i < maxc) begin @(posedge clk); #1; i++; end
        chk(tag, {31'b0, n_fall != s}, 1);
    endtask

    task automatic wait_nd(input string tag, input int maxc);
        int s = n_nd;
        int i = 0;
        while (n_nd == s && i < maxc) begin @(posedge clk); #1; i++; end
        chk(tag, {31'b0, n_nd != s}, 1);
    endtask

    task automatic wait_rises(input string tag, input int k, input int maxc);
        int i = 0;
        while (rises < k && i < maxc) begin @(posedge clk); #1; i++; end
        chk(tag, {31'b0, rises >= k}, 1);
    endtask

    initial begin
        int c, e, exp_e;
        rst_n = 1'b0; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", {31'b0, spi_cs_n}, 1);
        chk("rst_sclk", {31'b0, spi_sclk}, 0);
        chk("rst_data", {20'b0, data}, 0);
        chk("rst_new_data", {31'b0, new_data}, 0);
        chk("rst_busy", {31'b0, busy}, 0);

        // Back-to-back frames: nominal pattern then both extremes
        adc_q.push_back(12'hA5C);
        adc_q.push_back(12'h000);
        adc_q.push_back(12'hFFF);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fall("first_fall_seen", P + 20);
        chk("first_fall_edge", fall_e, P + 1);
        wait_nd("nd1_seen", 2 * P);
        wait_nd("nd2_seen", 2 * P);
        chk("nd_period_a", nd_e - nd_e_prev, P);
        wait_nd("nd3_seen", 2 * P);
        chk("nd_period_b", nd_e - nd_e_prev, P);
        repeat (10) @(posedge clk);
        #1;
        chk("data_hold", {20'b0, data}, 12'hFFF);

        // en dropped mid-frame: frame finishes, nothing further starts
        wait_fall("f4_seen", 2 * P);
        wait_rises("r5_seen", 5, 100);
        en = 1'b0;
        chk("busy_frame", {31'b0, busy}, 1);
        c = n_nd; e = n_fall;
        wait_nd("nd_en_drop_seen", P);
        repeat (3 * P) @(posedge clk);
        #1;
        chk("no_start_en0", n_fall - e, 0);
        chk("one_nd_en0", n_nd - c, 1);

        // en raised: start follows the next timer wrap
        adc_q.push_back(12'h5A3);
        c = ecnt;
        en = 1'b1;
        exp_e = ((c + P) / P) * P + 1;
        wait_fall("rearm_seen", 2 * P + 10);
        chk("rearm_edge", fall_e, exp_e);
        wait_nd("nd_rearm_seen", P);

        // Reset mid-frame
        wait_fall("f_rst_seen", 2 * P);
        wait_rises("r8_seen", 8, 100);
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", {31'b0, spi_cs_n}, 1);
        chk("arst_sclk", {31'b0, spi_sclk}, 0);
        chk("arst_data", {20'b0, data}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_new_data", {31'b0, new_data}, 0);
        sb.delete();
        repeat (5) @(posedge clk);
        c = n_nd;
        adc_q.push_back(12'h3C7);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (P - 10) @(posedge clk);
        #1;
        chk("no_nd_after_rst", n_nd - c, 0);
        chk("data_after_rst", {20'b0, data}, 0);
        wait_fall("f_post_rst_seen", 40);
        chk("post_rst_fall_edge", fall_e, P + 1);
        wait_nd("nd_post_rst_seen", P);
        chk("post_rst_data", {20'b0, data}, 12'h3C7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule
